spram_arbiter: RTL
==================

SPRAM_ARBITER -- requirements
Module: spram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, SPRAM word address width.
REQ-002 SHALL have parameter DATA_W, default 12, RGB444 pixel width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, write-buffer entries (power of two).
REQ-004 SHALL have parameter RD_STREAK_MAX, default 8, max consecutive reads granted while writes are pending.
REQ-005 Ports: clk  in  1  single system clock, rising edge.
REQ-006 Ports: rst  in  1  asynchronous, active-high reset.
REQ-007 Ports: wr_valid  in  1  writer (image receive path) presents a pixel.
REQ-008 Ports: wr_addr  in  ADDR_W  pixel address; wr_data  in  DATA_W  pixel value.
REQ-009 Ports: wr_ready  out  1  write buffer not full.
REQ-010 Ports: rd_req  in  1  display scan-out read request; rd_addr  in  ADDR_W  read address.
REQ-011 Ports: rd_ack  out  1  read granted this cycle.
REQ-012 Ports: rd_valid  out  1  rd_data valid; rd_data  out  DATA_W  read pixel.
REQ-013 Ports: spram_addr  out  ADDR_W; spram_wr_data  out  DATA_W; spram_wre  out  1; spram_rd_data  in  DATA_W.
REQ-014 Ports: fifo_level  out  clog2(FIFO_DEPTH)+1  buffered write count; wr_overflow  out  1  sticky dropped-write flag.

Function
REQ-015 Push into write FIFO on clk edge when wr_valid && wr_ready; wr_ready = (fifo_level != FIFO_DEPTH), from registered count only.
REQ-016 wr_valid while wr_ready=0: pixel dropped, wr_overflow set to 1 next edge, held until reset.
REQ-017 Pushed entry eligible for SPRAM no earlier than the cycle after the push (no fall-through).
REQ-018 Per-cycle arbitration, combinational from rd_req, fifo_level, rd_streak: fifo empty && rd_req -> READ; fifo non-empty && !rd_req -> WRITE; both -> READ unless rd_streak == RD_STREAK_MAX or fifo full, then WRITE; neither -> IDLE.
REQ-019 READ: spram_addr=rd_addr, spram_wre=0, rd_ack=1.
REQ-020 WRITE: spram_addr/spram_wr_data = FIFO head, spram_wre=1, FIFO pops that edge, rd_ack=0.
REQ-021 IDLE: spram_wre=0, rd_ack=0, spram_addr holds last driven value.
REQ-022 rd_valid = rd_ack delayed one clock; rd_data = spram_rd_data while rd_valid, else 0 (read latency exactly 1).
REQ-023 rd_streak: +1 on READ while fifo non-empty; cleared on WRITE or when fifo empty; saturates at RD_STREAK_MAX.
REQ-024 Simultaneous push and pop: level unchanged, both take effect; push on full is refused even if pop occurs same cycle.
REQ-025 FIFO pointers wrap modulo FIFO_DEPTH; order of writes to SPRAM equals push order.
REQ-026 No read-after-write forwarding: read of an address still buffered returns previous SPRAM content.
REQ-027 last_op register (IDLE/READ/WRITE) records the grant each cycle, used for debug and streak logic.

Reset
REQ-028 rst assertion immediately clears: FIFO pointers, fifo_level=0, rd_streak=0, last_op=IDLE, wr_overflow=0, rd_valid=0, rd_data=0, spram_addr=0, spram_wre=0.
REQ-029 rst mid-operation discards buffered writes and any in-flight read; wr_ready=1 first cycle after release.

Structure
REQ-030 Shared package holds op enum (OP_IDLE, OP_READ, OP_WRITE) and defaults ADDR_W=15, DATA_W=12.
REQ-031 Write buffer SHALL be sub-module spram_wr_fifo (synchronous, registered count, push/pop/full/empty/level).

Verification
REQ-032 Write only: push 0x375@0x0000, 0x535@0x0001 -> spram_wre=1 with those pairs on the 2 following-push cycles, fifo_level back to 0.
REQ-033 Read only: rd_req with rd_addr=0x0001 after REQ-032 -> rd_ack same cycle, rd_valid next cycle, rd_data=0x535.
REQ-034 Starvation: rd_req held high, 1 write buffered -> 8 READs then 1 WRITE, streak cleared, reads resume.
REQ-035 Full: 5 back-to-back pushes with rd_req held -> wr_ready=0 after 4th, 5th dropped, wr_overflow=1, FIFO-full forces WRITE next cycle.
REQ-036 Reset mid-stream: rst pulse with fifo_level=3 and rd_valid pending -> all outputs at reset values, no spram_wre after release.

Source files
------------

// File: rtl/spram_arbiter_pkg.sv
// rtl/spram_arbiter_pkg.sv - shared op encoding, default widths and grant rule for the SPRAM arbiter
package spram_arbiter_pkg;

    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 12;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } op_e;

    // Reads win by default; buffered writes win once the read streak saturates or the buffer is full.
    function automatic op_e arb_grant(
        input logic rd_req,
        input logic empty,
        input logic full,
        input logic streak_max
    );
        if (rd_req && (empty || !(full || streak_max))) begin
            return OP_READ;
        end
        if (!empty) begin
            return OP_WRITE;
        end
        return OP_IDLE;
    endfunction

endpackage

// File: rtl/spram_arbiter_if.sv
// rtl/spram_arbiter_if.sv - writer, scan-out reader and SPRAM port bundle of the arbiter
interface spram_arbiter_if
    import spram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    logic [ADDR_W-1:0] spram_addr;
    logic [DATA_W-1:0] spram_wr_data;
    logic              spram_wre;
    logic [DATA_W-1:0] spram_rd_data;

    logic [LVL_W-1:0]  fifo_level;
    logic              wr_overflow;
    op_e               last_op;

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_req, rd_addr, spram_rd_data,
        output wr_ready, rd_ack, rd_valid, rd_data,
               spram_addr, spram_wr_data, spram_wre,
               fifo_level, wr_overflow, last_op
    );

    modport master (
        output wr_valid, wr_addr, wr_data, rd_req, rd_addr, spram_rd_data,
        input  wr_ready, rd_ack, rd_valid, rd_data,
               spram_addr, spram_wr_data, spram_wre,
               fifo_level, wr_overflow, last_op
    );

endinterface

// File: rtl/spram_wr_fifo.sv
// rtl/spram_wr_fifo.sv - pixel write buffer with registered occupancy count
module spram_wr_fifo #(
    parameter int  ADDR_W = 15,
    parameter int  DATA_W = 12,
    parameter int  DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int LVL_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [LVL_W-1:0]  level_o
);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wptr_q] <= push_addr_i;
            data_mem[wptr_q] <= push_data_i;
        end
    end

    assign head_addr_o = addr_mem[rptr_q];
    assign head_data_o = data_mem[rptr_q];
    assign level_o     = level_q;

endmodule

// File: rtl/spram_arbiter.sv
// rtl/spram_arbiter.sv - single-port SPRAM arbiter between buffered pixel writes and display reads
module spram_arbiter
    import spram_arbiter_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int FIFO_DEPTH    = 4,
    parameter int RD_STREAK_MAX = 8
) (
    input  logic           clk,
    input  logic           rst,
    spram_arbiter_if.slave bus
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int STK_W = $clog2(RD_STREAK_MAX + 1);

    logic [LVL_W-1:0]  level;
    logic              full, empty, wr_ready;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    op_e               grant;

    logic [STK_W-1:0]  streak_q, streak_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_valid_q;
    logic              overflow_q;
    op_e               last_op_q;

    assign wr_ready = !full;

    spram_wr_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (bus.wr_valid && wr_ready),
        .push_addr_i (bus.wr_addr),
        .push_data_i (bus.wr_data),
        .pop_i       (grant == OP_WRITE),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .full_o      (full),
        .empty_o     (empty),
        .level_o     (level)
    );

    // Grant is forced idle while reset is held so the SPRAM port is quiet immediately.
    always_comb begin
        grant = OP_IDLE;
        if (!rst) begin
            grant = arb_grant(bus.rd_req, empty, full, streak_q == STK_W'(RD_STREAK_MAX));
        end
    end

    always_comb begin
        addr_d = addr_q;
        case (grant)
            OP_READ:  addr_d = bus.rd_addr;
            OP_WRITE: addr_d = head_addr;
            default:  addr_d = addr_q;
        endcase
    end

    always_comb begin
        streak_d = streak_q;
        if (grant == OP_WRITE || empty) begin
            streak_d = '0;
        end else if (grant == OP_READ && streak_q != STK_W'(RD_STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q   <= '0;
            addr_q     <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            last_op_q  <= OP_IDLE;
        end else begin
            streak_q   <= streak_d;
            addr_q     <= addr_d;
            rd_valid_q <= (grant == OP_READ);
            overflow_q <= overflow_q || (bus.wr_valid && !wr_ready);
            last_op_q  <= grant;
        end
    end

    assign bus.wr_ready      = wr_ready;
    assign bus.rd_ack        = (grant == OP_READ);
    assign bus.spram_wre     = (grant == OP_WRITE);
    assign bus.spram_addr    = addr_d;
    assign bus.spram_wr_data = (grant == OP_WRITE) ? head_data : '0;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.rd_data       = rd_valid_q ? bus.spram_rd_data : '0;
    assign bus.fifo_level    = level;
    assign bus.wr_overflow   = overflow_q;
    assign bus.last_op       = last_op_q;

endmodule
